// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of the single-port SDRAM controller: video has
// fixed priority, CPU and loader alternate, each access holds cs for a fixed window.
module sdram_port_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic [DATA_W-1:0] vid_data_o,
  output logic              vid_ack_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_ack_o,
  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_data_i,
  output logic [DATA_W-1:0] ldr_data_o,
  output logic              ldr_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_cs_o,
  output logic              mem_oe_o,
  output logic              mem_we_o,
  output logic              busy_o
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [1:0]          grant_reg, grant_next;
  logic                pref_ldr_reg, pref_ldr_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                we_reg, we_next;
  logic                capture;
  logic                sel_valid;
  logic [1:0]          sel;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   port_data [3];

  // pref_ldr_reg = 0 means the CPU wins a CPU/loader tie.
  always_comb begin
    sel_valid = 1'b1;
    sel       = 2'd0;
    if (vid_req_i)                   sel = 2'd0;
    else if (cpu_req_i && ldr_req_i) sel = pref_ldr_reg ? 2'd2 : 2'd1;
    else if (cpu_req_i)              sel = 2'd1;
    else if (ldr_req_i)              sel = 2'd2;
    else                             sel_valid = 1'b0;
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    grant_next    = grant_reg;
    pref_ldr_next = pref_ldr_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    we_next       = we_reg;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          state_next = ACCESS;
          cnt_next   = CNT_W'(ACCESS_CYCLES - 1);
          grant_next = sel;
          case (sel)
            2'd1: begin
              addr_next     = cpu_addr_i;
              wdata_next    = cpu_data_i;
              we_next       = cpu_we_i;
              pref_ldr_next = 1'b1;
            end
            2'd2: begin
              addr_next     = ldr_addr_i;
              wdata_next    = ldr_data_i;
              we_next       = ldr_we_i;
              pref_ldr_next = 1'b0;
            end
            default: begin
              addr_next  = vid_addr_i;
              wdata_next = '0;
              we_next    = 1'b0;
            end
          endcase
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          capture    = ~we_reg;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      grant_reg    <= 2'd0;
      pref_ldr_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      grant_reg    <= grant_next;
      pref_ldr_reg <= pref_ldr_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      we_reg       <= we_next;
    end
  end

  // Each port keeps its last read result until its own next read completes.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_port
    logic [DATA_W-1:0] data_reg;
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)                               data_reg <= '0;
      else if (capture && grant_reg == 2'(gi))   data_reg <= mem_data_i;
    end
    assign port_data[gi] = data_reg;
    assign ack[gi]       = (state_reg == DONE) && (grant_reg == 2'(gi));
  end

  assign vid_data_o = port_data[0];
  assign cpu_data_o = port_data[1];
  assign ldr_data_o = port_data[2];
  assign vid_ack_o  = ack[0];
  assign cpu_ack_o  = ack[1];
  assign ldr_ack_o  = ack[2];

  assign mem_addr_o = addr_reg;
  assign mem_data_o = wdata_reg;
  assign mem_cs_o   = (state_reg == ACCESS);
  assign mem_oe_o   = (state_reg == ACCESS) && !we_reg;
  assign mem_we_o   = (state_reg == ACCESS) && we_reg;
  assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: latency, strobes, data return,
// priority/round-robin order, and reset during an access.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              vid_req, cpu_req, cpu_we, ldr_req, ldr_we;
  logic [ADDR_W-1:0] vid_addr, cpu_addr, ldr_addr;
  logic [DATA_W-1:0] cpu_wdata, ldr_wdata, mem_rdata;
  logic [DATA_W-1:0] vid_dout, cpu_dout, ldr_dout, mem_wdata;
  logic              vid_ack, cpu_ack, ldr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs, mem_oe, mem_we, busy;

  int total = 0;
  int bad   = 0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(4)) dut (
    .clock_i(clk), .reset_i(rst),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_data_o(vid_dout), .vid_ack_o(vid_ack),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_data_o(cpu_dout), .cpu_ack_o(cpu_ack),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_data_i(ldr_wdata),
    .ldr_data_o(ldr_dout), .ldr_ack_o(ldr_ack),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata),
    .mem_cs_o(mem_cs), .mem_oe_o(mem_oe), .mem_we_o(mem_we), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? vid_ack : (p == 1) ? cpu_ack : ldr_ack;
  endfunction

  function automatic logic [DATA_W-1:0] dout_of(input int p);
    return (p == 0) ? vid_dout : (p == 1) ? cpu_dout : ldr_dout;
  endfunction

  task automatic set_req(input int p, input logic v);
    if (p == 0) vid_req = v;
    else if (p == 1) cpu_req = v;
    else ldr_req = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the arbiter idle and no other request pending.
  task automatic serve(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] mdata,
                       input logic [DATA_W-1:0] exp_dout);
    logic exp_we;
    exp_we = (p == 0) ? 1'b0 : we;
    if (p == 0) vid_addr = addr;
    if (p == 1) begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    if (p == 2) begin ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; end
    mem_rdata = mdata;
    set_req(p, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("p%0d_strobes_c%0d", p, k), {29'd0, mem_cs, mem_oe, mem_we},
               {29'd0, 1'b1, ~exp_we, exp_we});
      check_eq($sformatf("p%0d_addr_c%0d", p, k), 32'(mem_addr), 32'(addr));
      if (exp_we) check_eq($sformatf("p%0d_wdata_c%0d", p, k), 32'(mem_wdata), 32'(wdata));
      check_eq($sformatf("p%0d_ack_early_c%0d", p, k), 32'(ack_of(p)), 32'd0);
    end
    @(negedge clk);
    check_eq($sformatf("p%0d_ack", p), {29'd0, vid_ack, cpu_ack, ldr_ack}, 32'(3'b100 >> p));
    check_eq($sformatf("p%0d_done_strobes", p), {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
    check_eq($sformatf("p%0d_dout", p), 32'(dout_of(p)), 32'(exp_dout));
    set_req(p, 1'b0);
    @(negedge clk);
    check_eq($sformatf("p%0d_ack_after", p), 32'(ack_of(p)), 32'd0);
    check_eq($sformatf("p%0d_busy_after", p), 32'(busy), 32'd0);
    check_eq($sformatf("p%0d_dout_hold", p), 32'(dout_of(p)), 32'(exp_dout));
    $display("txn port=%0d we=%0d addr=%06h wdata=%02h dout=%02h", p, exp_we, addr, wdata, dout_of(p));
  endtask

  initial begin
    int  cs_seen, busy_seen, ack_seen, vt, ct, lt, nonvid, vid_raised, dropped_ack;
    int  order [$];
    int  exp_order [9] = '{1, 2, 1, 0, 2, 1, 2, 1, 2};

    rst = 1'b1;
    vid_req = 0; cpu_req = 0; ldr_req = 0; cpu_we = 0; ldr_we = 0;
    vid_addr = '0; cpu_addr = '0; ldr_addr = '0; cpu_wdata = '0; ldr_wdata = '0; mem_rdata = '0;

    // Reset then idle
    #3;
    check_eq("rst_strobes", {28'd0, mem_cs, mem_oe, mem_we, busy}, 32'd0);
    check_eq("rst_acks", {29'd0, vid_ack, cpu_ack, ldr_ack}, 32'd0);
    check_eq("rst_addr_data", {mem_addr, mem_wdata}, 32'd0);
    check_eq("rst_douts", {8'd0, vid_dout, cpu_dout, ldr_dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cs_seen = 0; busy_seen = 0; ack_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_cs) cs_seen++;
      if (busy) busy_seen++;
      if (vid_ack || cpu_ack || ldr_ack) ack_seen++;
    end
    check_eq("idle_cs_seen", 32'(cs_seen), 32'd0);
    check_eq("idle_busy_seen", 32'(busy_seen), 32'd0);
    check_eq("idle_ack_seen", 32'(ack_seen), 32'd0);
    $display("txn idle 20 cycles cs_seen=%0d busy_seen=%0d", cs_seen, busy_seen);

    // Single reads and writes on every port
    serve(1, 1'b0, 24'h001234, 8'h00, 8'hA5, 8'hA5);
    serve(2, 1'b0, 24'h00FF00, 8'h00, 8'h77, 8'h77);
    serve(2, 1'b1, 24'h00FFFF, 8'h3C, 8'h99, 8'h77);
    serve(0, 1'b0, 24'h000100, 8'h00, 8'hC3, 8'hC3);
    serve(1, 1'b1, 24'h123456, 8'h5E, 8'h11, 8'hA5);

    // Three-way contention right after reset
    do_reset();
    mem_rdata = 8'h42;
    cpu_we = 0; ldr_we = 0;
    vid_req = 1; cpu_req = 1; ldr_req = 1;
    vt = 0; ct = 0; lt = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (vid_ack) begin vt = c; vid_req = 0; end
      if (cpu_ack) begin ct = c; cpu_req = 0; end
      if (ldr_ack) begin lt = c; ldr_req = 0; end
    end
    vid_req = 0; cpu_req = 0; ldr_req = 0;
    check_eq("contend_vid_cycle", 32'(vt), 32'd5);
    check_eq("contend_cpu_cycle", 32'(ct), 32'd11);
    check_eq("contend_ldr_cycle", 32'(lt), 32'd17);
    $display("txn contention acks vid=%0d cpu=%0d ldr=%0d", vt, ct, lt);

    // Fairness with a video request inserted after the third grant
    cpu_req = 1; ldr_req = 1; ldr_we = 1; ldr_wdata = 8'h0F;
    nonvid = 0; vid_raised = 0;
    for (int c = 0; c < 150 && order.size() < 9; c++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (ack_of(p)) begin
          order.push_back(p);
          if (p == 0) vid_req = 0;
          else nonvid++;
        end
      end
      if (nonvid == 3 && vid_raised == 0) begin vid_req = 1; vid_raised = 1; end
    end
    vid_req = 0; cpu_req = 0; ldr_req = 0;
    check_eq("fair_count", 32'(order.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("fair_grant%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF,
               32'(exp_order[i]));
    $display("txn fairness grants=%p", order);
    @(negedge clk);
    @(negedge clk);

    // Request dropped before grant, and a request dropped mid-access
    cpu_we = 0; cpu_addr = 24'h000777; mem_rdata = 8'h6B;
    cpu_req = 1;
    @(negedge clk);
    ldr_req = 1;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    ldr_req = 0;
    ack_seen = 0; dropped_ack = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (cpu_ack) begin ack_seen++; check_eq("drop_cpu_dout", 32'(cpu_dout), 32'h6B); end
      if (ldr_ack) dropped_ack++;
    end
    check_eq("drop_cpu_ack_count", 32'(ack_seen), 32'd1);
    check_eq("drop_ldr_ack_count", 32'(dropped_ack), 32'd0);
    $display("txn dropped reqs cpu_acks=%0d ldr_acks=%0d", ack_seen, dropped_ack);

    // Reset during the second cycle of a CPU read
    cpu_we = 0; cpu_addr = 24'h000ABC; mem_rdata = 8'hEE;
    cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_cs_before", 32'(mem_cs), 32'd1);
    rst = 1'b1;
    cpu_req = 0;
    #1;
    check_eq("midrst_strobes", {28'd0, mem_cs, mem_oe, mem_we, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vid_ack || cpu_ack || ldr_ack) ack_seen++;
    end
    check_eq("midrst_no_ack", 32'(ack_seen), 32'd0);
    check_eq("midrst_cpu_dout", 32'(cpu_dout), 32'd0);
    $display("txn reset mid-access acks=%0d", ack_seen);
    serve(1, 1'b0, 24'h000ABC, 8'h00, 8'h5A, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
